// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants, response entry type and lane-mask helper.
// Used by dmem_pipe; parity build selected by DMEM_PARITY_EN.
package dmem_pkg;

  localparam int MAX_RD_LAT = 4;
  localparam int BYTE_W     = 8;
  localparam int DW_MAX     = 64;
  localparam int BE_MAX     = DW_MAX / BYTE_W;

  typedef struct packed {
    logic [DW_MAX-1:0] data;
    logic              err;
  } rsp_ent_t;

  function automatic logic [DW_MAX-1:0] lane_mask(
    input logic [BE_MAX-1:0] be
  );
    logic [DW_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < BE_MAX; i++)
      m[i*BYTE_W +: BYTE_W] = {BYTE_W{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// dmem_rsp_fifo: fall-through FIFO, head shown while count != 0.
// Pointers wrap modulo D; full/empty come from count.
module dmem_rsp_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(D+1)-1:0] count
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  logic [W-1:0]  store [D];
  logic [PW-1:0] wp, rp;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (count != '0);
  assign head   = store[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push)   wp <= nxt(wp);
      if (do_pop) rp <= nxt(rp);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) store[wp] <= push_data;
  end

endmodule

// File: rtl/dmem_pipe.sv
// dmem_pipe: byte-enable data memory with RD_LAT read pipe and credits.
// Define DMEM_PARITY_EN for per-byte parity storage and rsp_err.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter  int DW        = 32,
  parameter  int DEPTH     = 32,
  localparam int AW        = $clog2(DEPTH),
  parameter  int RD_LAT    = 1,
  parameter  int RSP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          Ewr,
  input  logic [AW-1:0] Dir,
  input  logic [DW-1:0] Din,
  input  logic [DW/8-1:0] Bsel,
  output logic [DW-1:0] Dout,
  output logic          rsp_valid,
  input  logic          rsp_ready
`ifdef DMEM_PARITY_EN
  ,
  output logic          rsp_err
`endif
);

  localparam int NB = DW / BYTE_W;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [DW-1:0]     mem [DEPTH];
  logic              acc, rd_acc, wr_acc;
  logic              push, pop;
  logic [CW-1:0]     outst, fifo_cnt;
  logic [BE_MAX-1:0] be_full;
  logic [DW_MAX-1:0] mask_full;
  logic [DW-1:0]     wmask;
  logic              rd_err;
  rsp_ent_t          ent0, push_ent, head_ent;
  logic              unused_ok;

  assign req_ready = outst < CW'(RSP_DEPTH);
  assign acc       = req_valid && req_ready;
  assign rd_acc    = acc && !Ewr;
  assign wr_acc    = acc && Ewr;
  assign rsp_valid = fifo_cnt != '0;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    be_full         = '0;
    be_full[NB-1:0] = Bsel;
  end

  assign mask_full = lane_mask(be_full);
  assign wmask     = mask_full[DW-1:0];

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[Dir] <= (mem[Dir] & ~wmask) | (Din & wmask);
  end

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] din_par, rd_par;

  always_comb begin
    din_par = '0;
    rd_par  = '0;
    for (int i = 0; i < NB; i++) begin
      din_par[i] = ^Din[i*BYTE_W +: BYTE_W];
      rd_par[i]  = ^mem[Dir][i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      for (int i = 0; i < NB; i++)
        if (Bsel[i]) par[Dir][i] <= din_par[i];
  end

  assign rd_err  = |(rd_par ^ par[Dir]);
  assign rsp_err = rsp_valid && head_ent.err;
`else
  assign rd_err = 1'b0;
`endif

  assign ent0 = '{data: DW_MAX'(mem[Dir]), err: rd_err};

  // Stage 0 is the array sample itself; the last stage feeds the queue.
  generate
    if (RD_LAT == 1) begin : g_direct
      assign push     = rd_acc;
      assign push_ent = ent0;
    end else begin : g_pipe
      logic     pv [RD_LAT-1];
      rsp_ent_t pe [RD_LAT-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < RD_LAT - 1; i++) begin
            pv[i] <= 1'b0;
            pe[i] <= '0;
          end
        end else begin
          pv[0] <= rd_acc;
          pe[0] <= ent0;
          for (int i = 1; i < RD_LAT - 1; i++) begin
            pv[i] <= pv[i-1];
            pe[i] <= pe[i-1];
          end
        end
      end

      assign push     = pv[RD_LAT-2];
      assign push_ent = pe[RD_LAT-2];
    end
  endgenerate

  dmem_rsp_fifo #(
    .W ($bits(rsp_ent_t)),
    .D (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .head      (head_ent),
    .count     (fifo_cnt)
  );

  // Credits cover in-flight stages too, so the queue never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) outst <= '0;
    else        outst <= outst + CW'(rd_acc) - CW'(pop);
  end

  assign Dout      = rsp_valid ? head_ent.data[DW-1:0] : '0;
  assign unused_ok = ^{head_ent, mask_full};

endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: three dmem_pipe instances (RD_LAT 1..3) vs queue model.
// Directed vectors; DMEM_PARITY_EN adds the parity corruption case.
module tb_dmem_pipe;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid, req_ready, ewr;
  logic [2:0]  rsp_valid, rsp_ready;
  logic [4:0]  dir  [3];
  logic [31:0] din  [3];
  logic [3:0]  bsel [3];
  logic [31:0] dout [3];
`ifdef DMEM_PARITY_EN
  logic [2:0]  rsp_err;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q     [3][$];
  logic [31:0] log_q [3][$];
  logic [31:0] mm    [3][32];
  logic [3:0]  bad   [3][32];
  int          ecnt;
  int          n_vec;
  int          n_bad;

  int          sa [5] = '{2, 1, 3, 6, 7};
  logic [31:0] sd [5] = '{11, 13, 12, 120, 56};

  for (genvar k = 0; k < 3; k++) begin : g_dut
    dmem_pipe #(
      .DW        (32),
      .DEPTH     (32),
      .RD_LAT    (k + 1),
      .RSP_DEPTH (4)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[k]),
      .req_ready (req_ready[k]),
      .Ewr       (ewr[k]),
      .Dir       (dir[k]),
      .Din       (din[k]),
      .Bsel      (bsel[k]),
      .Dout      (dout[k]),
      .rsp_valid (rsp_valid[k]),
      .rsp_ready (rsp_ready[k])
`ifdef DMEM_PARITY_EN
      ,
      .rsp_err   (rsp_err[k])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Model: accepted reads queue up with the edge they become visible.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) q[k].delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit hv, ac;
        int a;
        a  = int'(dir[k]);
        hv = q[k].size() > 0 && q[k][0].due <= ecnt;
        ac = req_valid[k] && q[k].size() < 4;
        if (hv && rsp_ready[k]) begin
          log_q[k].push_back(q[k][0].data);
          void'(q[k].pop_front());
        end
        if (ac && ewr[k]) begin
          for (int b = 0; b < 4; b++)
            if (bsel[k][b]) begin
              mm[k][a][8*b +: 8] = din[k][8*b +: 8];
              bad[k][a][b] = 1'b0;
            end
        end else if (ac) begin
          q[k].push_back('{data: mm[k][a],
                           err:  |bad[k][a],
                           due:  ecnt + 1 + k});
        end
      end
      ecnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        bit ev;
        ev = q[k].size() > 0 && q[k][0].due <= ecnt;
        chk($sformatf("rsp_valid%0d", k),
            32'(rsp_valid[k]), 32'(ev));
        chk($sformatf("req_ready%0d", k),
            32'(req_ready[k]), 32'(q[k].size() < 4));
        if (ev)
          chk($sformatf("dout%0d", k), dout[k], q[k][0].data);
`ifdef DMEM_PARITY_EN
        chk($sformatf("rsp_err%0d", k), 32'(rsp_err[k]),
            32'(ev && q[k][0].err));
`endif
      end
    end
  end

  task automatic op(
    input int k,
    input bit wr,
    input int a,
    input logic [31:0] d,
    input logic [3:0] be
  );
    int n;
    n = 0;
    req_valid[k] = 1'b1;
    ewr[k]       = wr;
    dir[k]       = a[4:0];
    din[k]       = d;
    bsel[k]      = be;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 0, 1);
    @(negedge clk);
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_log(input int k, input int n);
    int t;
    t = 0;
    while (log_q[k].size() < n && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("rsp_count%0d", k), log_q[k].size(), n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    ecnt      = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    ewr       = '0;
    for (int k = 0; k < 3; k++) begin
      dir[k]  = '0;
      din[k]  = '0;
      bsel[k] = '0;
      for (int a = 0; a < 32; a++) begin
        mm[k][a]  = '0;
        bad[k][a] = '0;
      end
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_rsp_valid", 32'(rsp_valid[k]), 0);
      chk("rst_req_ready", 32'(req_ready[k]), 1);
      chk("rst_dout", dout[k], 0);
    end

    // Write sweep then read back, RD_LAT=1.
    for (int i = 0; i < 5; i++) op(0, 1, sa[i], sd[i], 4'hF);
    log_q[0].delete();
    for (int i = 0; i < 5; i++) begin
      op(0, 0, sa[i], 0, 4'h0);
      chk("lat1_valid", 32'(rsp_valid[0]), 1);
      chk("lat1_dout", dout[0], sd[i]);
    end
    wait_log(0, 5);
    for (int i = 0; i < 5; i++) chk("sweep", log_q[0][i], sd[i]);

    // Byte enables.
    op(0, 1, 5, 32'hAABBCCDD, 4'hF);
    op(0, 1, 5, 32'h11223344, 4'b0101);
    log_q[0].delete();
    op(0, 0, 5, 0, 4'h0);
    wait_log(0, 1);
    chk("byte_en", log_q[0][0], 32'hAA22CC44);

    // RAW and WAR on address 9.
    log_q[0].delete();
    op(0, 1, 9, 77, 4'hF);
    op(0, 0, 9, 0, 4'h0);
    op(0, 0, 9, 0, 4'h0);
    op(0, 1, 9, 88, 4'hF);
    op(0, 0, 9, 0, 4'h0);
    wait_log(0, 3);
    chk("raw", log_q[0][0], 77);
    chk("war", log_q[0][1], 77);
    chk("war_new", log_q[0][2], 88);

    // Backpressure, RD_LAT=2.
    for (int i = 0; i < 6; i++) op(1, 1, 10 + i, 100 + i, 4'hF);
    log_q[1].delete();
    rsp_ready[1] = 1'b0;
    for (int i = 0; i < 4; i++) op(1, 0, 10 + i, 0, 4'h0);
    req_valid[1] = 1'b1;
    ewr[1]       = 1'b0;
    dir[1]       = 5'd14;
    for (int i = 0; i < 3; i++) begin
      chk("bp_stall", 32'(req_ready[1]), 0);
      chk("bp_held", q[1].size(), 4);
      @(negedge clk);
    end
    rsp_ready[1] = 1'b1;
    op(1, 0, 14, 0, 4'h0);
    op(1, 0, 15, 0, 4'h0);
    wait_log(1, 6);
    for (int i = 0; i < 6; i++) chk("bp_order", log_q[1][i], 100 + i);
    chk("bp_ready", 32'(req_ready[1]), 1);

    // Reset with two reads in flight, RD_LAT=3.
    op(2, 1, 20, 32'hDEAD0001, 4'hF);
    op(2, 1, 21, 32'hBEEF0002, 4'hF);
    op(2, 0, 20, 0, 4'h0);
    op(2, 0, 21, 0, 4'h0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    log_q[2].delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_flush", 32'(rsp_valid[2]), 0);
    end
    chk("rst_credit", 32'(req_ready[2]), 1);
    chk("rst_nolog", log_q[2].size(), 0);
    op(2, 0, 20, 0, 4'h0);
    op(2, 0, 21, 0, 4'h0);
    wait_log(2, 2);
    chk("rst_keep0", log_q[2][0], 32'hDEAD0001);
    chk("rst_keep1", log_q[2][1], 32'hBEEF0002);

`ifdef DMEM_PARITY_EN
    op(0, 1, 4, 32'h01020304, 4'hF);
    op(0, 1, 8, 32'h0000000F, 4'hF);
    g_dut[0].u_dut.par[4][0] = ~g_dut[0].u_dut.par[4][0];
    bad[0][4][0] = 1'b1;
    op(0, 0, 4, 0, 4'h0);
    chk("par_bad", 32'(rsp_err[0]), 1);
    op(0, 0, 8, 0, 4'h0);
    chk("par_good", 32'(rsp_err[0]), 0);
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_pipe.md
Name: dmem_pipe

Overview:
- Parametrised, synchronous single-port data memory for the MIPS datapath; successor to the 32x32 combinational data memory.
- Adds byte-enable writes, configurable read latency, and a valid/ready request interface.
- Read data returns through a response queue with backpressure.
- Sits between the load/store stage and the write-back mux.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of words; power of two.
- AW, $clog2(DEPTH), address width (derived, not overridden).
- RD_LAT, 1, read pipeline stages, 1..4.
- RSP_DEPTH, 4, response queue entries; must be >= RD_LAT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- Ewr  in  1  1 = write, 0 = read.
- Dir  in  AW  word address.
- Din  in  DW  write data.
- Bsel  in  DW/8  byte enables for writes, ignored on reads.
- Dout  out  DW  read data, valid when rsp_valid.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Accept = req_valid && req_ready at a rising edge. At most one operation per cycle.
- Write on accept: array[Dir] byte i <= Din byte i for each Bsel[i]=1; other bytes unchanged. No response is generated.
- Read on accept: array[Dir] is sampled at the accept edge, then passes through the remaining RD_LAT-1 register stages, then enters the response queue.
- Latency, queue empty and rsp_ready=1: rsp_valid is high in the cycle beginning RD_LAT edges after the accept edge, counting the accept edge as 1. With RD_LAT=1, data is visible in the cycle immediately after accept.
- Response queue: FIFO, fall-through. Dout/rsp_valid show the head entry. A pop occurs when rsp_valid && rsp_ready.
- Credit counter `outst` (0..RSP_DEPTH):
  - +1 on read accept; -1 on pop.
  - Simultaneous read accept and pop: unchanged.
  - req_ready = (outst < RSP_DEPTH). This applies to writes too, so the interface stays uniform.
  - Overflow of the queue is therefore impossible.
- Ordering: responses return in request order.
- Read-after-write, same address, back-to-back: the read returns the new data.
- Write-after-read, same address: the read returns the old data.
- Queue full, rsp_ready=0: req_ready=0 and the pipeline holds. In-flight stages always have reserved queue slots, so they advance freely.
- Pointer wrap: queue pointers wrap modulo RSP_DEPTH. Full and empty are distinguished by the count.
- Reset values, asynchronously on rst_n=0:
  - rsp_valid=0, Dout=0.
  - outst=0, req_ready=1 after release.
  - All pipeline valid bits 0, queue pointers and count 0.
- Array contents are not reset. Simulation initialises the array to 0.
- Reset mid-operation: in-flight reads are discarded with no response. A write accepted at the edge before reset assertion is retained.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte.
  - Written bytes update their parity bit.
  - The read path carries the recomputed parity check through the pipeline.
  - Extra output rsp_err (1 bit) is high with rsp_valid when any byte's parity mismatches. Reset value 0.
  - Hidden task/force hook in the bench flips a stored parity bit.
- When undefined: no parity storage, no rsp_err port, identical timing.

Decomposition:
- Package dmem_pkg:
  - Latency and depth limit constants: MAX_RD_LAT=4, BYTE_W=8.
  - Function for the byte-lane mask expansion.
  - Response entry typedef {data, err}.
- Sub-module dmem_rsp_fifo: parametrised fall-through FIFO (width, depth) with count output, used for the response queue.
- Array, read pipeline and credit logic stay in dmem_pipe.

Test Plan:
- Write sweep: Dir=2,Din=11; Dir=1,Din=13; Dir=3,Din=12; Dir=6,Din=120; Dir=7,Din=56 (Bsel=4'hF), then read each -> Dout 11,13,12,120,56 in order. RD_LAT=1: each rsp_valid arrives 1 cycle after its accept.
- Byte enables: write 32'hAABBCCDD to addr 5, then write 32'h11223344 with Bsel=4'b0101 -> read addr 5 returns 32'hAA22CC44.
- Backpressure, RD_LAT=2, RSP_DEPTH=4, rsp_ready=0:
  - Issue 6 reads -> exactly 4 accepted, then req_ready=0.
  - Raise rsp_ready -> 4 responses in order, req_ready returns to 1 and the remaining 2 complete.
- Hazards: write addr 9=77 then read addr 9 the next cycle -> 77. Read addr 9 then write 9=88 the next cycle -> read returns 77.
- Reset mid-flight: RD_LAT=3, 2 reads accepted, pulse rst_n low for 1 cycle -> no rsp_valid afterwards, outst=0, prior array contents intact on re-read.
- With DMEM_PARITY_EN: corrupt the parity of byte 0 at addr 4 -> read gives rsp_err=1; an uncorrupted address gives rsp_err=0.
